usb_hid_out: RTL and testbench

USB HID OUT-endpoint receiver for the amplifier's control interface. It accepts host-to-device output report packets from the USB packet engine and checks the data toggle, report ID and length. Each valid report is committed as a control byte and a volume byte to the amplifier control logic. While a committed report is still unconsumed, the block back-pressures the endpoint so the engine NAKs further OUT packets.

---
 rtl/usb_hid_out_pkg.sv | 19 +
 rtl/usb_hid_out_if.sv | 33 +++
 rtl/usb_hid_out.sv | 140 ++++++++++++++
 tb/tb_usb_hid_out.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_hid_out_pkg.sv
// usb_hid_pkg: shared state encoding, report defaults and byte layout
// for the USB HID OUT-endpoint receiver.
package usb_hid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } hid_state_t;

    localparam logic [7:0] REPORT_ID_DEF  = 8'h02;
    localparam int         REPORT_LEN_DEF = 3;

    localparam int IDX_ID      = 0;
    localparam int IDX_CONTROL = 1;
    localparam int IDX_VOLUME  = 2;

endpackage

// File: rtl/usb_hid_out_if.sv
// usb_hid_out_if: OUT-endpoint bus between the USB packet engine (master)
// and the HID report receiver (slave).
interface usb_hid_out_if;

    logic       Error;
    logic       OUT_Sequence;
    logic [7:0] OUT_Data;
    logic       OUT_Valid;
    logic       OUT_End;
    logic       OUT_WaitRequest;
    logic       OUT_Isochronous;

    modport master (
        output Error,
        output OUT_Sequence,
        output OUT_Data,
        output OUT_Valid,
        output OUT_End,
        input  OUT_WaitRequest,
        input  OUT_Isochronous
    );

    modport slave (
        input  Error,
        input  OUT_Sequence,
        input  OUT_Data,
        input  OUT_Valid,
        input  OUT_End,
        output OUT_WaitRequest,
        output OUT_Isochronous
    );

endinterface

// File: rtl/usb_hid_out.sv
// usb_hid_out: HID OUT-report receiver with toggle/ID/length checking.
// Define USB_HID_OUT_STATS_EN to build the saturating Drop_Count counter.
module usb_hid_out
    import usb_hid_pkg::*;
#(
    parameter logic [7:0] REPORT_ID  = REPORT_ID_DEF,
    parameter int         REPORT_LEN = REPORT_LEN_DEF
) (
    input  logic         Clk,
    input  logic         nReset,
    usb_hid_out_if.slave ep,
    output logic [7:0]   Report_Control,
    output logic [7:0]   Report_Volume,
    output logic         Report_Valid,
    input  logic         Report_Ready,
    output logic [7:0]   Drop_Count
);

    localparam int            CW      = $clog2(REPORT_LEN + 2);
    localparam logic [CW-1:0] CNT_LEN = CW'(REPORT_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(REPORT_LEN + 1);

    hid_state_t    state_q;
    hid_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] widx;
    logic [7:0]    rx_q [REPORT_LEN];
    logic          seq_q;
    logic          tog_q;
    logic [7:0]    ctrl_q;
    logic [7:0]    vol_q;

    logic take;
    logic ends;
    logic commit;
    logic toss_bad;
    logic bad_fmt;
    logic in_pkt;

    assign in_pkt  = (state_q == ST_IDLE) || (state_q == ST_RECEIVE);
    assign widx    = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign bad_fmt = (cnt_q != CNT_LEN) || (rx_q[IDX_ID] != REPORT_ID);

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        ends     = 1'b0;
        commit   = 1'b0;
        toss_bad = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RECEIVE: begin
                if (ep.Error) begin
                    state_d = ST_IDLE;
                end else begin
                    take = ep.OUT_Valid;
                    if (ep.OUT_End) begin
                        ends    = 1'b1;
                        state_d = ST_CHECK;
                    end else if (ep.OUT_Valid) begin
                        state_d = ST_RECEIVE;
                    end
                end
            end
            ST_CHECK: begin
                // A malformed packet was still ACKed, so its toggle is consumed
                if (bad_fmt) begin
                    toss_bad = 1'b1;
                    state_d  = ST_IDLE;
                end else if (seq_q != tog_q) begin
                    state_d = ST_IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Report_Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= 1'b0;
            tog_q   <= 1'b0;
            ctrl_q  <= 8'h00;
            vol_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (take) begin
                cnt_q <= (widx == CNT_MAX) ? CNT_MAX : widx + 1'b1;
            end else if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end
            if (ends) seq_q <= ep.OUT_Sequence;
            if (commit) begin
                ctrl_q <= rx_q[IDX_CONTROL];
                vol_q  <= rx_q[IDX_VOLUME];
            end
            if (commit || toss_bad) tog_q <= ~tog_q;
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < REPORT_LEN; i++) begin
            if (take && widx == CW'(i)) rx_q[i] <= ep.OUT_Data;
        end
    end

`ifdef USB_HID_OUT_STATS_EN
    logic [7:0] drop_q;
    logic       drop_evt;

    assign drop_evt = toss_bad || (in_pkt && ep.Error);

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            drop_q <= 8'h00;
        end else if (drop_evt && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'h01;
        end
    end

    assign Drop_Count = drop_q;
`else
    logic unused_in_pkt;
    assign unused_in_pkt = in_pkt;
    assign Drop_Count    = 8'h00;
`endif

    assign Report_Control     = ctrl_q;
    assign Report_Volume      = vol_q;
    assign Report_Valid       = (state_q == ST_HOLD);
    assign ep.OUT_WaitRequest = (state_q == ST_HOLD);
    assign ep.OUT_Isochronous = 1'b0;

endmodule

// File: tb/tb_usb_hid_out.sv
// tb_usb_hid_out: directed plus random packets against a packet-level
// reference model of the HID OUT receiver.
module tb_usb_hid_out;

    typedef logic [7:0] bq_t[$];

    localparam logic [7:0] TB_ID  = 8'h02;
    localparam int         TB_LEN = 3;
`ifdef USB_HID_OUT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] rctl;
    logic [7:0] rvol;
    logic [7:0] drop;
    logic       rvld;

    int n_chk  = 0;
    int n_fail = 0;

    bit         m_tog  = 1'b0;
    logic [7:0] m_ctl  = 8'h00;
    logic [7:0] m_vol  = 8'h00;
    int         m_drop = 0;

    usb_hid_out_if ep();

    usb_hid_out #(
        .REPORT_ID (TB_ID),
        .REPORT_LEN(TB_LEN)
    ) dut (
        .Clk           (clk),
        .nReset        (rst_n),
        .ep            (ep),
        .Report_Control(rctl),
        .Report_Volume (rvol),
        .Report_Valid  (rvld),
        .Report_Ready  (rdy),
        .Drop_Count    (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_drop();
        return STATS ? 8'(m_drop) : 8'h00;
    endfunction

    function automatic void drop_inc();
        if (m_drop < 255) m_drop++;
    endfunction

    task automatic chk_out(input string tag);
        chk({tag, "_ctl"}, rctl, m_ctl);
        chk({tag, "_vol"}, rvol, m_vol);
        chk({tag, "_drop"}, drop, exp_drop());
    endtask

    // hold < 0 leaves a committed report pending in Hold
    task automatic send_pkt(input bq_t b, input bit seq, input int err_at,
                            input int hold);
        bit bad;
        bit commit;
        for (int i = 0; i < b.size(); i++) begin
            if (i == err_at) begin
                ep.Error = 1'b1;
                tick();
                ep.Error = 1'b0;
                drop_inc();
                chk("err_vld", rvld, 0);
                chk_out("err");
                return;
            end
            ep.OUT_Valid    = 1'b1;
            ep.OUT_Data     = b[i];
            ep.OUT_Sequence = seq;
            tick();
            ep.OUT_Valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        ep.OUT_End      = 1'b1;
        ep.OUT_Sequence = seq;
        tick();
        ep.OUT_End = 1'b0;
        chk("check_vld", rvld, 0);
        bad    = (b.size() != TB_LEN) || (b[0] != TB_ID);
        commit = !bad && (seq == m_tog);
        if (bad) begin
            drop_inc();
            m_tog = !m_tog;
        end else if (commit) begin
            m_ctl = b[1];
            m_vol = b[2];
            m_tog = !m_tog;
        end
        tick();
        chk("vld", rvld, commit);
        chk("wait", ep.OUT_WaitRequest, commit);
        chk_out("pkt");
        if (commit && hold >= 0) begin
            for (int h = 0; h < hold; h++) begin
                ep.OUT_Valid = 1'($urandom_range(0, 1));
                ep.OUT_Data  = 8'($urandom);
                tick();
                chk("hold_wait", ep.OUT_WaitRequest, 1);
                chk("hold_vld", rvld, 1);
            end
            ep.OUT_Valid = 1'b0;
            chk_out("hold");
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            chk("rel_vld", rvld, 0);
            chk("rel_wait", ep.OUT_WaitRequest, 0);
        end
    endtask

    initial begin
        ep.Error        = 1'b0;
        ep.OUT_Sequence = 1'b0;
        ep.OUT_Data     = 8'h00;
        ep.OUT_Valid    = 1'b0;
        ep.OUT_End      = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_vld", rvld, 0);
        chk("rst_wait", ep.OUT_WaitRequest, 0);
        chk("rst_iso", ep.OUT_Isochronous, 0);
        chk_out("rst");
        rst_n = 1'b1;
        tick();

        send_pkt('{8'h02, 8'h5A, 8'h30}, 1'b0, -1, 2);
        send_pkt('{8'h02, 8'h5A, 8'h30}, 1'b0, -1, 0);
        send_pkt('{8'h03, 8'h11, 8'h22}, 1'b1, -1, 0);
        send_pkt('{8'h02, 8'h11, 8'h22, 8'h33}, 1'b1, -1, 0);
        send_pkt('{8'h02, 8'h11}, 1'b1, -1, 0);
        send_pkt('{8'h02, 8'h44, 8'h55}, 1'b0, -1, 10);
        send_pkt('{8'h02, 8'h66, 8'h77}, 1'b1, 1, 0);
        send_pkt('{8'h02, 8'h66, 8'h77}, 1'b1, -1, 1);
        send_pkt('{8'h02, 8'h9C, 8'hE1}, 1'b0, -1, -1);

        rst_n = 1'b0;
        tick();
        m_tog  = 1'b0;
        m_ctl  = 8'h00;
        m_vol  = 8'h00;
        m_drop = 0;
        chk("hrst_vld", rvld, 0);
        chk("hrst_wait", ep.OUT_WaitRequest, 0);
        chk_out("hrst");
        rst_n = 1'b1;
        tick();
        send_pkt('{8'h02, 8'h21, 8'h43}, 1'b0, -1, 0);

        for (int k = 0; k < 60; k++) begin
            bq_t b;
            int  len;
            bit  sq;
            int  err;
            len = ($urandom_range(0, 9) < 6) ? TB_LEN : $urandom_range(1, 5);
            b = {};
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            if ($urandom_range(0, 4) != 0) b[0] = TB_ID;
            sq  = ($urandom_range(0, 3) != 0) ? m_tog : !m_tog;
            err = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            send_pkt(b, sq, err, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (260) begin
            ep.Error = 1'b1;
            tick();
            ep.Error = 1'b0;
            drop_inc();
        end
        chk("sat_drop", drop, exp_drop());
        send_pkt('{8'h07, 8'h00, 8'h00}, m_tog, -1, 0);
        chk("sat_hold", drop, exp_drop());

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
